lsu: RTL and testbench

- Load/store unit directly downstream of the execute stage in the RV32 core.
- Takes one memory request per transaction: address, store data and funct3 from the execute stage.
- Drives a word-wide memory bus with a request/grant plus read-valid handshake, and returns aligned, extended load data for register writeback.
- Replaces the current single-cycle memory path, so the core can stall on memory latency.

---
 rtl/lsu_pkg.sv | 24 ++
 rtl/lsu_align.sv | 50 +++++
 rtl/lsu.sv | 125 ++++++++++++
 tb/tb_lsu.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - funct3 encodings, FSM state type and access legality helper for the LSU.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} lsu_state_t;

  // Reserved encodings count as illegal so they can be trapped alongside misalignment.
  function automatic logic is_misaligned(input logic [2:0] func, input logic [1:0] addr_lo);
    logic bad;
    case (func)
      F3_B, F3_BU: bad = 1'b0;
      F3_H, F3_HU: bad = addr_lo[0];
      F3_W:        bad = (addr_lo != 2'b00);
      default:     bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational store lane steering and load extraction/extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  func,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  // Sub-size offsets ignore the low address bits they cannot use, forcing alignment.
  always_comb begin
    wstrb     = 4'b1111;
    wdata_rep = wdata;
    case (func)
      F3_B, F3_BU: begin
        wstrb     = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      F3_H, F3_HU: begin
        wstrb     = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
      end
      default: begin
        wstrb     = 4'b1111;
        wdata_rep = wdata;
      end
    endcase
  end

  always_comb begin
    rbyte     = rdata[{addr_lo, 3'b000} +: 8];
    rhalf     = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    rdata_ext = rdata;
    case (func)
      F3_B:    rdata_ext = {{24{rbyte[7]}}, rbyte};
      F3_BU:   rdata_ext = {24'h0, rbyte};
      F3_H:    rdata_ext = {{16{rhalf[15]}}, rhalf};
      F3_HU:   rdata_ext = {16'h0, rhalf};
      default: rdata_ext = rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit FSM bridging execute requests to a word bus.
// Optional misaligned/reserved access trap: LSU_MISALIGN_TRAP_EN.
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [2:0]        req_func,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_t state, state_nxt;

  logic              wen_q;
  logic [2:0]        func_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              trap;

  logic [3:0]        strb;
  logic [DATA_W-1:0] wdata_rep;
  logic [DATA_W-1:0] rdata_ext;

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = is_misaligned(req_func, req_addr[1:0]);
`else
  assign trap = 1'b0;
`endif

  lsu_align u_align (
    .func      (func_q),
    .addr_lo   (addr_q[1:0]),
    .wdata     (wdata_q),
    .rdata     (mem_rdata),
    .wstrb     (strb),
    .wdata_rep (wdata_rep),
    .rdata_ext (rdata_ext)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      wen_q   <= 1'b0;
      func_q  <= F3_B;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_valid) begin
        wen_q   <= req_wen;
        func_q  <= req_func;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        rdata_q <= '0;
        err_q   <= trap;
      end
      if (state == WAIT && mem_rvalid) begin
        rdata_q <= rdata_ext;
      end
    end
  end

  // Bus outputs are derived only from latched request fields, so they hold steady through a stall.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wstrb = 4'b0000;
    mem_wdata = '0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = trap ? RESP : REQ;
      end
      REQ: begin
        mem_req  = 1'b1;
        mem_we   = wen_q;
        mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
        if (wen_q) begin
          mem_wstrb = strb;
          mem_wdata = wdata_rep;
        end
        if (mem_gnt) state_nxt = wen_q ? RESP : WAIT;
      end
      WAIT: begin
        if (mem_rvalid) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - directed self-checking bench for the load/store unit.
module tb_lsu;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [2:0]  req_func;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [3:0]  r_wstrb;
  logic        r_we, r_err, r_ready0, r_ready_after;
  int          r_seen, r_stable, n_rsp, rsp_cyc;

  lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wen    (req_wen),
    .req_func   (req_func),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_req    (mem_req),
    .mem_gnt    (mem_gnt),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wstrb  (mem_wstrb),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept in cycle 0; gnt arrives gnt_dly cycles after REQ starts, rvalid rv_dly cycles after gnt.
  task automatic run_txn(input logic wen, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] wd, input int gnt_dly, input int rv_dly,
                         input logic [31:0] rd);
    int cyc;
    int gnt_cyc;
    req_valid = 1'b1;
    req_wen   = wen;
    req_func  = f;
    req_addr  = a;
    req_wdata = wd;
    r_ready0  = req_ready;
    r_seen = 0; r_stable = 1; n_rsp = 0; rsp_cyc = -1; gnt_cyc = -1;
    r_addr = '0; r_wdata = '0; r_wstrb = '0; r_we = 1'b0; r_rdata = '0; r_err = 1'b0;
    r_ready_after = 1'b0;
    tick();
    req_valid = 1'b0;
    cyc = 1;
    while (cyc < 40) begin
      mem_rvalid = (gnt_cyc >= 0) && (cyc == gnt_cyc + rv_dly);
      mem_rdata  = rd;
      mem_gnt    = mem_req && (cyc >= 1 + gnt_dly);
      if (mem_req) begin
        if (r_seen == 0) begin
          r_addr = mem_addr; r_wdata = mem_wdata; r_wstrb = mem_wstrb; r_we = mem_we;
        end else if (mem_addr !== r_addr || mem_wdata !== r_wdata || mem_wstrb !== r_wstrb) begin
          r_stable = 0;
        end
        if (req_ready !== 1'b0) r_stable = 0;
        r_seen++;
      end
      if (mem_gnt) gnt_cyc = cyc;
      if (rsp_valid) begin
        n_rsp++;
        rsp_cyc = cyc;
        r_rdata = rsp_rdata;
        r_err   = rsp_err;
      end
      tick();
      cyc++;
      if (n_rsp > 0) begin
        r_ready_after = req_ready;
        break;
      end
    end
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    checks++; if (mem_wstrb !== 4'h0) begin errors++; $display("FAIL reset_mem_wstrb: got %b want 0000", mem_wstrb); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
  endtask

  task automatic test_store_byte();
    run_txn(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 0, 1, 32'h0);
    checks++; if (r_ready0 !== 1'b1) begin errors++; $display("FAIL sb_ready: got %b want 1", r_ready0); end
    checks++; if (r_addr !== 32'h0000_1000) begin errors++; $display("FAIL sb_addr: got %h want 00001000", r_addr); end
    checks++; if (r_wstrb !== 4'b1000) begin errors++; $display("FAIL sb_wstrb: got %b want 1000", r_wstrb); end
    checks++; if (r_wdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL sb_wdata: got %h want a5a5a5a5", r_wdata); end
    checks++; if (r_we !== 1'b1) begin errors++; $display("FAIL sb_we: got %b want 1", r_we); end
    checks++; if (rsp_cyc != 2) begin errors++; $display("FAIL sb_latency: got %0d want 2", rsp_cyc); end
    checks++; if (r_rdata !== 32'h0) begin errors++; $display("FAIL sb_rdata: got %h want 0", r_rdata); end
  endtask

  task automatic test_load_byte();
    run_txn(1'b0, 3'b000, 32'h0000_2001, 32'h0, 0, 3, 32'h1234_8056);
    checks++; if (r_rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_rdata: got %h want ffffff80", r_rdata); end
    checks++; if (rsp_cyc != 5) begin errors++; $display("FAIL lb_latency: got %0d want 5", rsp_cyc); end
    checks++; if (r_wstrb !== 4'b0000 || r_we !== 1'b0) begin errors++; $display("FAIL lb_bus_read: got we=%b wstrb=%b want we=0 wstrb=0000", r_we, r_wstrb); end
    checks++; if (r_addr !== 32'h0000_2000) begin errors++; $display("FAIL lb_addr: got %h want 00002000", r_addr); end
    run_txn(1'b0, 3'b100, 32'h0000_2001, 32'h0, 0, 3, 32'h1234_8056);
    checks++; if (r_rdata !== 32'h0000_0080) begin errors++; $display("FAIL lbu_rdata: got %h want 00000080", r_rdata); end
  endtask

  task automatic test_half();
    run_txn(1'b0, 3'b001, 32'h0000_2002, 32'h0, 0, 1, 32'h8001_FFFF);
    checks++; if (r_rdata !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_rdata: got %h want ffff8001", r_rdata); end
    checks++; if (rsp_cyc != 3) begin errors++; $display("FAIL lh_latency: got %0d want 3", rsp_cyc); end
    run_txn(1'b0, 3'b101, 32'h0000_2002, 32'h0, 0, 1, 32'h8001_FFFF);
    checks++; if (r_rdata !== 32'h0000_8001) begin errors++; $display("FAIL lhu_rdata: got %h want 00008001", r_rdata); end
    run_txn(1'b1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 0, 1, 32'h0);
    checks++; if (r_wstrb !== 4'b1100) begin errors++; $display("FAIL sh_wstrb: got %b want 1100", r_wstrb); end
    checks++; if (r_wdata !== 32'hBEEF_BEEF) begin errors++; $display("FAIL sh_wdata: got %h want beefbeef", r_wdata); end
  endtask

  task automatic test_stall();
    run_txn(1'b1, 3'b010, 32'h0000_5000, 32'h1122_3344, 5, 1, 32'h0);
    checks++; if (r_stable != 1) begin errors++; $display("FAIL stall_stable: got %0d want 1", r_stable); end
    checks++; if (r_seen != 6) begin errors++; $display("FAIL stall_req_cycles: got %0d want 6", r_seen); end
    checks++; if (n_rsp != 1) begin errors++; $display("FAIL stall_rsp_count: got %0d want 1", n_rsp); end
    checks++; if (rsp_cyc != 7) begin errors++; $display("FAIL stall_latency: got %0d want 7", rsp_cyc); end
    checks++; if (r_wstrb !== 4'b1111 || r_wdata !== 32'h1122_3344) begin errors++; $display("FAIL stall_sw_bus: got wstrb=%b wdata=%h want 1111 11223344", r_wstrb, r_wdata); end
  endtask

  task automatic test_reset_mid();
    int pulses;
    req_valid = 1'b1; req_wen = 1'b0; req_func = 3'b010; req_addr = 32'h0000_3000; req_wdata = '0;
    tick();
    req_valid = 1'b0;
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (mem_req !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_idle: got mem_req=%b req_ready=%b want 0 1", mem_req, req_ready); end
    pulses = 0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h5555_AAAA;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid === 1'b1) pulses++;
      tick();
      mem_rvalid = 1'b0;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL rstmid_no_rsp: got %0d pulses want 0", pulses); end
    run_txn(1'b0, 3'b010, 32'h0000_3000, 32'h0, 0, 1, 32'hDEAD_BEEF);
    checks++; if (r_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rstmid_lw: got %h want deadbeef", r_rdata); end
    checks++; if (n_rsp != 1) begin errors++; $display("FAIL rstmid_lw_rsp: got %0d want 1", n_rsp); end
  endtask

  task automatic test_misaligned();
    run_txn(1'b0, 3'b010, 32'h0000_4002, 32'h0, 0, 1, 32'hCAFE_F00D);
`ifdef LSU_MISALIGN_TRAP_EN
    checks++; if (r_seen != 0) begin errors++; $display("FAIL mis_no_req: got %0d req cycles want 0", r_seen); end
    checks++; if (rsp_cyc != 1) begin errors++; $display("FAIL mis_latency: got %0d want 1", rsp_cyc); end
    checks++; if (r_err !== 1'b1) begin errors++; $display("FAIL mis_err: got %b want 1", r_err); end
    checks++; if (r_rdata !== 32'h0) begin errors++; $display("FAIL mis_rdata: got %h want 0", r_rdata); end
`else
    checks++; if (r_addr !== 32'h0000_4000) begin errors++; $display("FAIL mis_addr: got %h want 00004000", r_addr); end
    checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL mis_err: got %b want 0", r_err); end
    checks++; if (r_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL mis_rdata: got %h want cafef00d", r_rdata); end
    run_txn(1'b0, 3'b011, 32'h0000_6001, 32'h0, 0, 1, 32'h8765_4321);
    checks++; if (r_rdata !== 32'h8765_4321 || r_addr !== 32'h0000_6000) begin errors++; $display("FAIL reserved_word: got rdata=%h addr=%h want 87654321 00006000", r_rdata, r_addr); end
`endif
  endtask

  task automatic test_back_to_back();
    run_txn(1'b1, 3'b000, 32'h0000_7002, 32'h0000_0033, 0, 1, 32'h0);
    checks++; if (r_ready_after !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", r_ready_after); end
    run_txn(1'b0, 3'b000, 32'h0000_7002, 32'h0, 0, 1, 32'h00C3_0000);
    checks++; if (r_ready0 !== 1'b1) begin errors++; $display("FAIL b2b_accept: got %b want 1", r_ready0); end
    checks++; if (r_rdata !== 32'hFFFF_FFC3) begin errors++; $display("FAIL b2b_lb: got %h want ffffffc3", r_rdata); end
    checks++; if (rsp_cyc != 3) begin errors++; $display("FAIL b2b_latency: got %0d want 3", rsp_cyc); end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_func = 3'b000; req_addr = '0; req_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    test_reset();
    test_store_byte();
    test_load_byte();
    test_half();
    test_stall();
    test_reset_mid();
    test_misaligned();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
